// File: rtl/operand_entry.sv
// ---------------------------------------------------------------------------
// operand_entry
//
// Keypad operand-entry front end for the calculator. Digits arrive one per
// strobe in decimal or hex (radix latched at the first digit of an entry),
// are accumulated into a two-digit magnitude, and an optional sign is toggled
// while typing. On enter the magnitude is range-checked and committed to the
// ALU as a 6-bit two's-complement operand; an out-of-range entry parks the
// block in ERROR until clear.
//
// Ports
//   clk           system clock, all state on rising edge
//   rst           asynchronous, active-high reset
//   display_mode  0 decimal, 1 hex; sampled only at the first digit
//   digit_valid   one-cycle strobe, digit present
//   digit         key value 0x0-0xF
//   neg_toggle    one-cycle strobe, flip sign of the current entry
//   enter         one-cycle strobe, commit entry
//   clear         one-cycle strobe, abandon entry / leave ERROR
//   value         committed signed operand, held until next commit
//   value_valid   one-cycle pulse, first cycle value holds a new operand
//   ent_digit0    most recently entered digit (ones / low nibble)
//   ent_digit1    previously entered digit (tens / high nibble)
//   ent_negative  sign of the current entry
//   error         high while in ERROR
//   busy          high while in ENTRY
//
// Strobe priority within one cycle: clear > enter > neg_toggle > digit_valid.
// Only the highest-priority asserted strobe acts.
// ---------------------------------------------------------------------------
module operand_entry #(
   parameter int MAX_DIGITS = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       display_mode,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       neg_toggle,
   input  logic       enter,
   input  logic       clear,
   output logic [5:0] value,
   output logic       value_valid,
   output logic [3:0] ent_digit0,
   output logic [3:0] ent_digit1,
   output logic       ent_negative,
   output logic       error,
   output logic       busy
);

   // State encoding
   localparam logic [1:0] S_IDLE  = 2'd0;   // no digits yet
   localparam logic [1:0] S_ENTRY = 2'd1;   // 1..MAX_DIGITS digits held
   localparam logic [1:0] S_DONE  = 2'd2;   // operand committed
   localparam logic [1:0] S_ERROR = 2'd3;   // out-of-range entry, wait for clear

   localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

   // Largest committable magnitudes for each sign (6-bit two's complement)
   localparam logic [7:0] MAX_POS = 8'd31;
   localparam logic [7:0] MAX_NEG = 8'd32;

   // -----------------------------------------------------------------------
   // State registers
   // -----------------------------------------------------------------------
   logic [1:0] state_q,       state_d;
   logic [7:0] mag_q,         mag_d;
   logic [1:0] count_q,       count_d;
   logic       radix_hex_q,   radix_hex_d;
   logic       neg_q,         neg_d;
   logic [3:0] dig0_q,        dig0_d;
   logic [3:0] dig1_q,        dig1_d;
   logic [5:0] value_q,       value_d;
   logic       value_valid_q, value_valid_d;
   logic       error_q,       error_d;
   logic       busy_q,        busy_d;

   // -----------------------------------------------------------------------
   // Digit datapath helpers
   // -----------------------------------------------------------------------
   logic        fresh_entry;   // digit would start a new entry (IDLE/DONE)
   logic        hex_sel;       // radix that applies to the incoming digit
   logic        digit_legal;   // digit < radix
   logic [7:0]  mag_base;      // magnitude the digit is appended to
   logic [1:0]  count_base;
   logic [3:0]  dig0_base;
   logic [7:0]  radix_mult;
   logic [15:0] mag_prod;
   logic [7:0]  mag_next;

   // Commit datapath helpers
   logic        in_range;
   logic [5:0]  mag_lo;
   logic [5:0]  signed_mag;

   // NOTE: every signal written in an always_comb gets a default at the top
   // of the block, so no path can leave it unassigned and infer a latch.
   always_comb begin
      fresh_entry = (state_q != S_ENTRY);
      hex_sel     = fresh_entry ? display_mode : radix_hex_q;
      digit_legal = hex_sel || (digit <= 4'd9);

      // A new entry starts from an empty accumulator; the clear of mag,
      // count and the digit registers happens before the append.
      mag_base    = fresh_entry ? 8'd0 : mag_q;
      count_base  = fresh_entry ? 2'd0 : count_q;
      dig0_base   = fresh_entry ? 4'd0 : dig0_q;

      radix_mult  = hex_sel ? 8'd16 : 8'd10;
      mag_prod    = mag_base * radix_mult;
      // Two digits max: 15*16+15 = 255 still fits in the low byte.
      mag_next    = mag_prod[7:0] + {4'd0, digit};
   end

   always_comb begin
      in_range   = neg_q ? (mag_q <= MAX_NEG) : (mag_q <= MAX_POS);
      mag_lo     = mag_q[5:0];
      // Magnitude 32 negates to 6'b100000, and -0 folds to 0.
      signed_mag = neg_q ? (6'd0 - mag_lo) : mag_lo;
   end

   // -----------------------------------------------------------------------
   // Next-state logic
   // -----------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      mag_d         = mag_q;
      count_d       = count_q;
      radix_hex_d   = radix_hex_q;
      neg_d         = neg_q;
      dig0_d        = dig0_q;
      dig1_d        = dig1_q;
      value_d       = value_q;
      value_valid_d = 1'b0;

      if (clear) begin
         // Abandon from any state; the last committed operand is kept.
         state_d = S_IDLE;
         mag_d   = 8'd0;
         count_d = 2'd0;
         neg_d   = 1'b0;
         dig0_d  = 4'd0;
         dig1_d  = 4'd0;
      end else if (enter) begin
         if (state_q == S_IDLE || state_q == S_ENTRY) begin
            if (in_range) begin
               value_d       = signed_mag;
               value_valid_d = 1'b1;
               state_d       = S_DONE;
            end else begin
               state_d = S_ERROR;
            end
         end
      end else if (neg_toggle) begin
         if (state_q == S_IDLE || state_q == S_ENTRY) begin
            neg_d = ~neg_q;
         end
      end else if (digit_valid) begin
         // Illegal digits and anything in ERROR leave all state untouched.
         if (state_q != S_ERROR && digit_legal) begin
            if (fresh_entry) begin
               radix_hex_d = display_mode;
               mag_d       = 8'd0;
               count_d     = 2'd0;
               dig0_d      = 4'd0;
               dig1_d      = 4'd0;
               state_d     = S_ENTRY;
               // A sign chosen in IDLE carries into the entry; a sign left
               // over from the previous committed operand does not.
               if (state_q == S_DONE) begin
                  neg_d = 1'b0;
               end
            end
            if (count_base < MAX_CNT) begin
               mag_d   = mag_next;
               count_d = count_base + 2'd1;
               dig1_d  = dig0_base;
               dig0_d  = digit;
            end
         end
      end

      // Status flags are registered straight from the next state so they
      // line up with the state they describe.
      error_d = (state_d == S_ERROR);
      busy_d  = (state_d == S_ENTRY);
   end

   // -----------------------------------------------------------------------
   // Registers
   // -----------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbours, independent of order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         mag_q         <= 8'd0;
         count_q       <= 2'd0;
         radix_hex_q   <= 1'b0;
         neg_q         <= 1'b0;
         dig0_q        <= 4'd0;
         dig1_q        <= 4'd0;
         value_q       <= 6'd0;
         value_valid_q <= 1'b0;
         error_q       <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         mag_q         <= mag_d;
         count_q       <= count_d;
         radix_hex_q   <= radix_hex_d;
         neg_q         <= neg_d;
         dig0_q        <= dig0_d;
         dig1_q        <= dig1_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         error_q       <= error_d;
         busy_q        <= busy_d;
      end
   end

   assign value        = value_q;
   assign value_valid  = value_valid_q;
   assign ent_digit0   = dig0_q;
   assign ent_digit1   = dig1_q;
   assign ent_negative = neg_q;
   assign error        = error_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_operand_entry.sv
// ---------------------------------------------------------------------------
// tb_operand_entry
//
// Self-checking bench for operand_entry. Directed scenarios followed by
// random strobes; every cycle all outputs are compared with a reference
// model that keeps the entered digits in a queue and derives the magnitude,
// displayed digits and committed value arithmetically.
// ---------------------------------------------------------------------------
module tb_operand_entry;

   logic       clk = 1'b0;
   logic       rst;
   logic       display_mode;
   logic       digit_valid;
   logic [3:0] digit;
   logic       neg_toggle;
   logic       enter;
   logic       clear;
   logic [5:0] value;
   logic       value_valid;
   logic [3:0] ent_digit0;
   logic [3:0] ent_digit1;
   logic       ent_negative;
   logic       error;
   logic       busy;

   operand_entry dut (
      .clk          (clk),
      .rst          (rst),
      .display_mode (display_mode),
      .digit_valid  (digit_valid),
      .digit        (digit),
      .neg_toggle   (neg_toggle),
      .enter        (enter),
      .clear        (clear),
      .value        (value),
      .value_valid  (value_valid),
      .ent_digit0   (ent_digit0),
      .ent_digit1   (ent_digit1),
      .ent_negative (ent_negative),
      .error        (error),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int step_no  = 0;

   // -----------------------------------------------------------------------
   // Reference model
   // -----------------------------------------------------------------------
   typedef enum int {M_IDLE, M_ENTRY, M_DONE, M_ERROR} mstate_t;

   mstate_t m_state;
   int      m_digits[$];   // digits of the current entry, oldest first
   bit      m_neg;
   bit      m_hex;
   int      m_value;       // committed operand as a plain signed integer
   bit      m_vv;

   function automatic int model_mag();
      int m = 0;
      foreach (m_digits[i]) m = m * (m_hex ? 16 : 10) + m_digits[i];
      return m;
   endfunction

   task automatic model_reset();
      m_state = M_IDLE;
      m_digits.delete();
      m_neg   = 0;
      m_hex   = 0;
      m_value = 0;
      m_vv    = 0;
   endtask

   task automatic model_step(input bit c, input bit e, input bit n,
                             input bit dv, input int d, input bit mode);
      int  mag;
      bit  fresh;
      bit  hex;
      m_vv = 0;
      if (c) begin
         m_state = M_IDLE;
         m_digits.delete();
         m_neg = 0;
      end else if (e) begin
         if (m_state == M_IDLE || m_state == M_ENTRY) begin
            mag = model_mag();
            if (mag <= (m_neg ? 32 : 31)) begin
               m_value = m_neg ? -mag : mag;
               m_vv    = 1;
               m_state = M_DONE;
            end else begin
               m_state = M_ERROR;
            end
         end
      end else if (n) begin
         if (m_state == M_IDLE || m_state == M_ENTRY) m_neg = !m_neg;
      end else if (dv && m_state != M_ERROR) begin
         fresh = (m_state != M_ENTRY);
         hex   = fresh ? mode : m_hex;
         if (hex || d < 10) begin
            if (fresh) begin
               if (m_state == M_DONE) m_neg = 0;
               m_digits.delete();
               m_hex   = mode;
               m_state = M_ENTRY;
            end
            if (m_digits.size() < 2) m_digits.push_back(d);
         end
      end
   endtask

   // -----------------------------------------------------------------------
   // Comparison helpers
   // -----------------------------------------------------------------------
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s step=%0d observed=0x%0h expected=0x%0h", tag, step_no, obs, exp);
      end
   endtask

   task automatic check_all();
      int sz;
      int e0;
      int e1;
      sz = m_digits.size();
      e0 = (sz >= 1) ? m_digits[sz-1] : 0;
      e1 = (sz >= 2) ? m_digits[sz-2] : 0;
      chk("value",        {2'b00, value},        8'(m_value & 63));
      chk("value_valid",  {7'd0, value_valid},   {7'd0, m_vv});
      chk("ent_digit0",   {4'd0, ent_digit0},    8'(e0));
      chk("ent_digit1",   {4'd0, ent_digit1},    8'(e1));
      chk("ent_negative", {7'd0, ent_negative},  {7'd0, m_neg});
      chk("error",        {7'd0, error},         {7'd0, m_state == M_ERROR});
      chk("busy",         {7'd0, busy},          {7'd0, m_state == M_ENTRY});
   endtask

   // One clock of stimulus: drive on the falling edge, model the rising
   // edge, compare shortly after it.
   task automatic step(input bit c, input bit e, input bit n,
                       input bit dv, input int d, input bit mode);
      @(negedge clk);
      clear        = c;
      enter        = e;
      neg_toggle   = n;
      digit_valid  = dv;
      digit        = 4'(d);
      display_mode = mode;
      @(posedge clk);
      model_step(c, e, n, dv, d, mode);
      #1;
      step_no++;
      check_all();
   endtask

   task automatic idle();        step(0, 0, 0, 0, 0, display_mode); endtask
   task automatic key(input int d, input bit mode); step(0, 0, 0, 1, d, mode); endtask
   task automatic do_enter();    step(0, 1, 0, 0, 0, display_mode); endtask
   task automatic do_clear();    step(1, 0, 0, 0, 0, display_mode); endtask
   task automatic do_neg();      step(0, 0, 1, 0, 0, display_mode); endtask

   // -----------------------------------------------------------------------
   // Stimulus
   // -----------------------------------------------------------------------
   initial begin
      rst          = 1'b1;
      display_mode = 1'b0;
      digit_valid  = 1'b0;
      digit        = 4'd0;
      neg_toggle   = 1'b0;
      enter        = 1'b0;
      clear        = 1'b0;
      model_reset();
      #2;
      check_all();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Decimal entry 25
      key(2, 0);
      key(5, 0);
      do_enter();
      chk("dec25_value", {2'b00, value}, 8'b0001_1001);
      idle();
      chk("dec25_pulse_end", {7'd0, value_valid}, 8'd0);

      // Negative boundary -32, then -33 overflows
      do_clear();
      do_neg();
      key(3, 0);
      key(2, 0);
      do_enter();
      chk("neg32_value", {2'b00, value}, 8'b0010_0000);
      key(3, 0);
      key(3, 0);
      do_neg();
      do_enter();
      chk("neg33_error", {7'd0, error}, 8'd1);
      key(1, 0);               // ignored in ERROR
      do_neg();                // ignored in ERROR
      do_enter();              // ignored in ERROR
      do_clear();

      // Hex entry, mode flips mid-entry: 0x1F = 31
      key(1, 1);
      key(15, 0);
      do_enter();
      chk("hex31_value", {2'b00, value}, 8'd31);
      key(10, 0);              // illegal first decimal digit, stays DONE
      key(4, 0);
      key(10, 0);              // illegal in decimal entry
      do_enter();
      chk("dec4_value", {2'b00, value}, 8'd4);

      // Hex 0x20 = 32 positive is out of range
      key(2, 1);
      key(0, 0);
      do_enter();
      do_clear();

      // Third digit ignored
      key(1, 0);
      key(2, 0);
      key(7, 0);
      do_enter();
      chk("overflow12_value", {2'b00, value}, 8'd12);

      // Priority: clear beats enter; neg beats digit
      key(5, 0);
      step(1, 1, 0, 0, 0, 0);
      chk("clr_enter_no_pulse", {7'd0, value_valid}, 8'd0);
      key(3, 0);
      step(0, 0, 1, 1, 7, 0);
      do_enter();
      chk("neg3_value", {2'b00, value}, 8'b0011_1101);

      // Held strobes act every cycle; -0 commits 0
      do_clear();
      do_neg();
      do_enter();
      key(9, 0);
      key(9, 0);
      key(9, 0);
      do_neg();
      do_neg();
      do_neg();
      do_clear();

      // Async reset mid-entry, between edges
      key(1, 0);
      @(negedge clk);
      digit_valid = 1'b0;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      step_no++;
      check_all();
      @(negedge clk);
      rst = 1'b0;
      do_enter();
      chk("reset_enter_pulse", {7'd0, value_valid}, 8'd1);

      // Random strobes
      for (int i = 0; i < 600; i++) begin
         bit c, e, n, dv, mode;
         int d;
         c    = ($urandom_range(0, 99) < 5);
         e    = ($urandom_range(0, 99) < 12);
         n    = ($urandom_range(0, 99) < 12);
         dv   = ($urandom_range(0, 99) < 55);
         mode = ($urandom_range(0, 3) == 0);
         d    = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                           : int'($urandom_range(0, 15));
         step(c, e, n, dv, d, mode);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_entry.md
# operand_entry

Sequential operand-entry block for the calculator front end. It accepts keypad digits one at a time in decimal or hex, plus a sign toggle, and accumulates them into a two-digit magnitude. On an enter strobe it range-checks the magnitude and commits a 6-bit signed operand to the ALU. Its live-entry outputs (two digits plus sign) drive the seven-segment path while the user types; committed results go the opposite way through the signed-to-digit converter.

## Interface
- MAX_DIGITS, 2: digits accepted per operand; further digits are ignored.
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- display_mode  input  1  0 decimal, 1 hex; latched at the first digit of an entry
- digit_valid  input  1  one-cycle strobe, digit present
- digit  input  4  key value 0x0–0xF
- neg_toggle  input  1  one-cycle strobe, flips sign of the current entry
- enter  input  1  one-cycle strobe, commit entry
- clear  input  1  one-cycle strobe, abandon entry / leave ERROR
- value  output  6  committed signed operand, held until next commit
- value_valid  output  1  one-cycle pulse when value updates
- ent_digit0  output  4  most recently entered digit (ones)
- ent_digit1  output  4  previously entered digit (tens/high nibble)
- ent_negative  output  1  current entry sign
- error  output  1  high while in ERROR
- busy  output  1  high in ENTRY state

## Operation
- States: IDLE (no digits), ENTRY (1..MAX_DIGITS digits), DONE (result committed), ERROR.
- Per-cycle event priority: clear > enter > neg_toggle > digit_valid; only the highest-priority asserted strobe acts.
- Internal: mag[7:0], count[1:0], radix_hex (latched mode), neg.
- Digit accept: legal when digit < radix (≤9 decimal, any value hex). Illegal digits are ignored with no state change. When count < MAX_DIGITS: mag ← mag·radix + digit, ent_digit1 ← ent_digit0, ent_digit0 ← digit, count+1. When count = MAX_DIGITS: ignored.
- First digit (from IDLE or DONE): clear mag, digit registers, and count first; latch radix_hex ← display_mode; go to ENTRY. From DONE, neg also clears to 0.
- display_mode changes during ENTRY have no effect.
- neg_toggle: in IDLE/ENTRY, neg ← ~neg. Ignored in DONE and ERROR.
- enter in IDLE/ENTRY: legal range is mag ≤ 31 when neg = 0 and mag ≤ 32 when neg = 1. In range: value ← neg ? −mag : mag (6-bit two's complement; −0 commits 0), value_valid pulses, go to DONE. Out of range: value unchanged, no pulse, go to ERROR.
- enter in IDLE commits 0.
- enter in DONE or ERROR is ignored.
- clear: from any state go to IDLE; zero mag, count, neg, and digit registers. value is unchanged.
- ERROR: only clear exits. digit_valid and neg_toggle are ignored.

## Timing
- Reset (async): state IDLE; value = 0, value_valid = 0, ent_digit0 = ent_digit1 = 0, ent_negative = 0, error = 0, busy = 0, mag = 0, count = 0.
- All outputs are registered.
- Strobe sampled at edge N → outputs reflect it after edge N (one-cycle latency).
- value_valid is high for exactly one cycle, coincident with the first cycle value holds the new operand.
- error and busy are decoded from state registers and valid the cycle after the transition.
- Back-to-back strobes on consecutive cycles are each processed; no idle cycle is required.
- Strobes held high for multiple cycles act once per cycle; edge detection belongs to the keypad debouncer upstream.

## Test plan
- Decimal entry: mode 0; digits 2, 5; enter → value = 6'b011001 (25), value_valid for 1 cycle; state DONE; ent_digit1/ent_digit0 = 2/5.
- Negative boundary: mode 0; neg_toggle; digits 3, 2; enter → value = 6'b100000 (−32). Repeat with 3, 3 → error = 1, no value_valid, value keeps the prior operand; clear → IDLE, error = 0.
- Hex entry with mid-entry mode change: mode 1; digit 1; mode → 0; digit F; enter → value = 6'b011111 (31). Decimal mode with digit A → ignored, count unchanged.
- Overflow digits: mode 0; digits 1, 2, 7 → ent digits 1/2, third digit ignored; enter → 12.
- Priority: clear and enter asserted in the same cycle during ENTRY → IDLE, no value_valid. neg_toggle and digit_valid in the same cycle → only the sign flips.
- Async reset: assert rst mid-ENTRY between clock edges → all outputs 0 immediately. Enter with no digits after reset → value 0 with value_valid.
